// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM output stages: state encoding and default widths.
// Benches import this to probe the dead-time FSM state.
package pwm_pkg;

    localparam int DT_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_OFF = 3'd0,
        ST_LO  = 3'd1,
        ST_HI  = 3'd2,
        ST_DTH = 3'd3,
        ST_DTL = 3'd4
    } pwm_state_t;

endpackage

// File: rtl/pwm_dt_counter.sv
// Dead-band down-counter: parallel load, decrement that holds at zero, and a zero flag.
module pwm_dt_counter #(
    parameter int DT_W = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            dec,
    input  logic [DT_W-1:0] load_val,
    output logic [DT_W-1:0] cnt,
    output logic            zero
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-pair generator with break-before-make dead time, pulse swallowing,
// enable gating and a sticky fault trip. Outputs are a registered decode of the next state.
//
//  state  | meaning
//  -------+------------------------------------------
//  ST_OFF | both sides off, waiting for en and no fault
//  ST_LO  | low side driven
//  ST_HI  | high side driven
//  ST_DTH | dead band, heading to high side
//  ST_DTL | dead band, heading to low side
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            clr_fault,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            in_dead,
    output logic            fault_latched
);

    pwm_state_t      state, state_next;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic            fault_next;
    logic [DT_W-1:0] cnt;

    pwm_dt_counter #(.DT_W(DT_W)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (dead_time),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        // fault wins over clear when both arrive together
        fault_next = fault ? 1'b1 : (clr_fault ? 1'b0 : fault_latched);

        if (fault || fault_latched || !en) begin
            state_next = ST_OFF;
        end else begin
            case (state)
                ST_OFF: begin
                    state_next = pwm_in ? ST_DTH : ST_DTL;
                    cnt_load   = 1'b1;
                end
                ST_LO: begin
                    if (pwm_in) begin
                        state_next = ST_DTH;
                        cnt_load   = 1'b1;
                    end
                end
                ST_HI: begin
                    if (!pwm_in) begin
                        state_next = ST_DTL;
                        cnt_load   = 1'b1;
                    end
                end
                ST_DTH: begin
                    if (!pwm_in)       state_next = ST_LO;
                    else if (cnt_zero) state_next = ST_HI;
                    else               cnt_dec    = 1'b1;
                end
                ST_DTL: begin
                    if (pwm_in)        state_next = ST_HI;
                    else if (cnt_zero) state_next = ST_LO;
                    else               cnt_dec    = 1'b1;
                end
                default: state_next = ST_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_OFF;
            pwm_hi        <= 1'b0;
            pwm_lo        <= 1'b0;
            in_dead       <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_next;
            pwm_hi        <= (state_next == ST_HI);
            pwm_lo        <= (state_next == ST_LO);
            in_dead       <= (state_next == ST_DTH) || (state_next == ST_DTL);
            fault_latched <= fault_next;
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: vector table, hand-written corner sequences,
// and randomized stimulus against a behavioural gate-pair model.
module tb_pwm_deadtime;
    import pwm_pkg::*;

    localparam int DT_W = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            en, pwm_in, fault, clr_fault;
    logic [DT_W-1:0] dead_time;
    logic            pwm_hi, pwm_lo, in_dead, fault_latched;

    int checks = 0;
    int errors = 0;

    pwm_deadtime #(.DT_W(DT_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault         (fault),
        .clr_fault     (clr_fault),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .in_dead       (in_dead),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    // Model: running or not; when running either settled on a side or owing off cycles.
    bit m_run, m_dead, m_side, m_head, m_fl;
    int m_owed;

    task automatic model_reset();
        m_run = 0; m_dead = 0; m_side = 0; m_head = 0; m_fl = 0; m_owed = 0;
    endtask

    task automatic model_edge();
        bit stop;
        stop = fault || m_fl || !en;
        if (stop) begin
            m_run  = 0;
            m_dead = 0;
        end else if (!m_run) begin
            m_run  = 1;
            m_dead = 1;
            m_head = pwm_in;
            m_owed = int'(dead_time);
        end else if (m_dead) begin
            if (pwm_in != m_head) begin
                m_dead = 0;
                m_side = pwm_in;
            end else if (m_owed == 0) begin
                m_dead = 0;
                m_side = m_head;
            end else begin
                m_owed = m_owed - 1;
            end
        end else if (pwm_in != m_side) begin
            m_dead = 1;
            m_head = pwm_in;
            m_owed = int'(dead_time);
        end
        if (fault)          m_fl = 1;
        else if (clr_fault) m_fl = 0;
    endtask

    function automatic logic [3:0] model_out();
        return {m_run && !m_dead && m_side, m_run && !m_dead && !m_side, m_dead, m_fl};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called with clk low; applies current inputs across one posedge.
    task automatic step(input bit use_model);
        model_edge();
        @(posedge clk);
        #1;
        chk("overlap", 32'(pwm_hi & pwm_lo), 32'd0);
        if (use_model)
            chk("model", 32'({pwm_hi, pwm_lo, in_dead, fault_latched}), 32'(model_out()));
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 0; pwm_in = 0; fault = 0; clr_fault = 0; dead_time = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       en, p, f, c;
        logic [7:0] dt;
        logic [3:0] exp;   // {hi, lo, dead, fault_latched}
    } vec_t;

    vec_t vecs[18];
    int   runlen;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0100};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b1000};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b1000};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b1000};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 4'b0001};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 4'b0001};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 4'b0001};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 4'b0000};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0010};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 4'b1000};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 4'b0000};

        do_reset();
        @(negedge clk);
        chk("reset", 32'({pwm_hi, pwm_lo, in_dead, fault_latched}), 32'd0);

        foreach (vecs[i]) begin
            en = vecs[i].en; pwm_in = vecs[i].p; fault = vecs[i].f;
            clr_fault = vecs[i].c; dead_time = vecs[i].dt;
            step(1'b0);
            chk($sformatf("vec%0d", i), 32'({pwm_hi, pwm_lo, in_dead, fault_latched}),
                32'(vecs[i].exp));
        end
        fault = 0; clr_fault = 0;

        // Short pulse inside the low phase is swallowed.
        do_reset();
        en = 1; dead_time = 8'd5; pwm_in = 0;
        repeat (8) step(1'b1);
        chk("sp_lo", 32'(pwm_lo), 32'd1);
        pwm_in = 1;
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            chk("sp_dead", 32'({pwm_hi, pwm_lo, in_dead}), 32'b001);
        end
        pwm_in = 0;
        step(1'b1);
        chk("sp_back", 32'({pwm_hi, pwm_lo, in_dead}), 32'b010);

        // Zero dead time: single both-off cycle each way.
        dead_time = 8'd0; pwm_in = 1;
        step(1'b1);
        chk("dt0_r1", 32'({pwm_hi, pwm_lo, in_dead}), 32'b001);
        step(1'b1);
        chk("dt0_r2", 32'({pwm_hi, pwm_lo, in_dead}), 32'b100);
        pwm_in = 0;
        step(1'b1);
        chk("dt0_f1", 32'({pwm_hi, pwm_lo, in_dead}), 32'b001);
        step(1'b1);
        chk("dt0_f2", 32'({pwm_hi, pwm_lo, in_dead}), 32'b010);

        // en dropped mid dead band, then re-enable needs a full band.
        dead_time = 8'd4; pwm_in = 1;
        step(1'b1); step(1'b1);
        en = 0;
        step(1'b1);
        chk("en_off", 32'({pwm_hi, pwm_lo, in_dead}), 32'b000);
        en = 1;
        for (int k = 0; k < 5; k++) begin
            step(1'b1);
            chk("en_band", 32'({pwm_hi, pwm_lo, in_dead}), 32'b001);
        end
        step(1'b1);
        chk("en_hi", 32'({pwm_hi, pwm_lo, in_dead}), 32'b100);

        // Async reset while high side is driven.
        reset_n = 1'b0;
        #1;
        chk("areset", 32'({pwm_hi, pwm_lo, in_dead, fault_latched}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        en = 1; pwm_in = 1; dead_time = 8'd2;
        step(1'b1);
        chk("rst_band", 32'({pwm_hi, pwm_lo, in_dead}), 32'b001);
        repeat (3) step(1'b1);

        // Randomized run against the model.
        runlen = 0;
        for (int n = 0; n < 4000; n++) begin
            if (runlen == 0) begin
                pwm_in = ~pwm_in;
                runlen = $urandom_range(1, 12);
            end
            runlen--;
            if ($urandom_range(0, 49) == 0) dead_time = 8'($urandom_range(0, 6));
            fault     = ($urandom_range(0, 149) == 0);
            clr_fault = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) en = ~en;
            else if (!en && $urandom_range(0, 9) == 0) en = 1;
            step(1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
